fifo_stream_reader: RTL and testbench

//  Read-side companion to the team fifo: pops words from fifo and presents them on a

---
 rtl/fifo_stream_reader.sv | 87 ++++++++
 tb/tb_fifo_stream_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side fifo front end: pops the fifo and presents words on a valid/ready stream.
// Optional: FIFO_STREAM_READER_STATS_EN adds the word_count delivered-word counter.
module fifo_stream_reader #(
  parameter int DATA_WIDTH  = 22,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [COUNT_WIDTH-1:0] word_count
`endif
);

  logic                  pending;
  logic [DATA_WIDTH-1:0] slot [2];
  logic [1:0]            occ;
  logic                  head;

  logic       active;
  logic       pop;
  logic       push;
  logic       wr_idx;
  logic [1:0] occ_next;

  assign active = ce & ~rst;

  assign out_valid = active & (occ != 2'd0);
  assign out_data  = slot[head];
  assign occupancy = occ;

  assign pop  = out_valid & out_ready;
  assign push = active & pending;

  assign occ_next = occ + {1'b0, push} - {1'b0, pop};

  // Only request when a slot is free for the word landing next cycle.
  assign fifo_rd_en = active & ~fifo_empty & (occ_next < 2'd2);

  // With occ=2 and a pop this lands on the slot being freed.
  assign wr_idx = head ^ occ[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      occ     <= 2'd0;
      head    <= 1'b0;
      slot[0] <= '0;
      slot[1] <= '0;
    end else if (ce) begin
      pending <= fifo_rd_en;
      occ     <= occ_next;
      if (pop) begin
        head <= ~head;
      end
      if (push) begin
        slot[wr_idx] <= fifo_rd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ce) begin
      assert (!((occ == 2'd2) && push && !pop));
      assert (!((occ == 2'd0) && pop));
    end
  end

`ifdef FIFO_STREAM_READER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      word_count <= '0;
    end else if (pop) begin
      word_count <= word_count + COUNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural fifo plus an in-order scoreboard.
// Build with FIFO_STREAM_READER_STATS_EN to also exercise word_count.
module tb_fifo_stream_reader;

  localparam int DW = 22;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b1;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
`ifdef FIFO_STREAM_READER_STATS_EN
  logic [CW-1:0] word_count;
`endif

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DATA_WIDTH (DW),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .occupancy   (occupancy)
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    .word_count  (word_count)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural fifo with one-cycle registered read data.
  logic [DW-1:0] mem [4096];
  int wr_ptr = 0;
  int rd_ptr = 0;
  bit pop_q = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (pop_q) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic push_word(logic [DW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  // Scoreboard: words popped from the fifo, oldest first, not yet delivered.
  logic [DW-1:0] sb [$];
  bit inflight = 1'b0;
  bit mon_en = 1'b0;
  int delivered = 0;
  int wc_model = 0;

  always @(negedge clk) begin
    int exp_occ;
    bit exp_valid;
    bit exp_rden;
    bit popn;
    popn = ce && fifo_rd_en && !fifo_empty;
    if (mon_en) begin
      exp_occ = sb.size() - int'(inflight);
      exp_valid = ce && !rst && (exp_occ != 0);
      exp_rden = ce && !rst && !fifo_empty &&
        (exp_occ + int'(inflight) - int'(exp_valid && out_ready) < 2);
      chk("occupancy", 32'(occupancy), 32'(exp_occ));
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rden));
`ifdef FIFO_STREAM_READER_STATS_EN
      chk("word_count", 32'(word_count), 32'(wc_model % 256));
`endif
      if (rst) begin
        sb.delete();
        inflight = 1'b0;
        wc_model = 0;
      end else if (ce) begin
        if (out_valid && out_ready) begin
          chk("xfer_known", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(sb.pop_front()));
          end
          delivered++;
          wc_model++;
        end
        if (popn) begin
          sb.push_back(mem[rd_ptr]);
        end
        inflight = popn;
      end
    end
    pop_q = popn;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    rst = 1'b0;
    ce = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 1000 && !ok; i++) begin
      step();
      ok = (wr_ptr == rd_ptr) && (sb.size() == 0) && !inflight;
    end
    chk("drain_done", 32'(ok), 32'd1);
  endtask

  task automatic reset_mid(int stall);
    int d0;
    for (int i = 0; i < 6; i++) begin
      push_word(DW'(32'h40 + 32'(stall * 8 + i)));
    end
    out_ready = 1'b0;
    ce = 1'b1;
    repeat (stall) step();
    rst = 1'b1;
    step();
    chk("rst_mid_occ", 32'(occupancy), 32'd0);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    d0 = delivered;
    drain();
    chk("rst_mid_count", 32'(delivered - d0), 32'd4);
  endtask

  initial begin
    int d0;

    // Reset with words waiting in the fifo.
    for (int i = 1; i <= 3; i++) push_word(DW'(i));
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_occ", 32'(occupancy), 32'd0);
    end

    // Streaming latency and throughput.
    for (int i = 4; i <= 8; i++) push_word(DW'(i));
    mon_en = 1'b1;
    out_ready = 1'b1;
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) chk("lat_rd_en", 32'(fifo_rd_en), 32'd1);
      chk("stream_valid", 32'(out_valid), 32'(k >= 2 && k < 10));
      if (k >= 2 && k < 10) chk("stream_data", 32'(out_data), 32'(k - 1));
      step();
    end

    // Backpressure.
    for (int i = 0; i < 5; i++) push_word(DW'(32'h10 + 32'(i)));
    out_ready = 1'b0;
    repeat (6) step();
    chk("bp_occ", 32'(occupancy), 32'd2);
    chk("bp_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("bp_fifo_cnt", 32'(wr_ptr - rd_ptr), 32'd3);
    d0 = delivered;
    drain();
    chk("bp_count", 32'(delivered - d0), 32'd5);

    // Clock-enable gating.
    for (int i = 0; i < 6; i++) push_word(DW'(32'h20 + 32'(i)));
    out_ready = 1'b1;
    d0 = delivered;
    for (int i = 0; i < 20; i++) begin
      ce = (i % 2 == 0);
      step();
    end
    drain();
    chk("ce_count", 32'(delivered - d0), 32'd6);

    // Reset with a pending read, then with a full buffer.
    reset_mid(2);
    reset_mid(4);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      ce = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      rst = ($urandom_range(299) == 0);
      if ($urandom_range(1) == 1 && wr_ptr < 3500) push_word(DW'($urandom));
      step();
    end
    drain();

`ifdef FIFO_STREAM_READER_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 300; i++) push_word(DW'(i));
    drain();
    chk("wc_300", 32'(word_count), 32'd44);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
